// File: rtl/loop_controller_if.sv
// Handshake and counter bundle between upstream, loop_controller, the down-counter
// stage and the worker datapath.
interface loop_controller_if #(
  parameter int m = 6
) ();
  logic         start;
  logic [m-1:0] n_in;
  logic         abort;
  logic         z;
  logic [m-1:0] i;
  logic [1:0]   opc;
  logic [m-1:0] n;
  logic         step_req;
  logic         step_ack;
  logic [m-1:0] idx;
  logic         busy;
  logic         done;

  // Environment side: upstream, counter and worker.
  modport master (
    output start, n_in, abort, z, i, step_ack,
    input  opc, n, step_req, idx, busy, done
  );

  // Controller side.
  modport slave (
    input  start, n_in, abort, z, i, step_ack,
    output opc, n, step_req, idx, busy, done
  );
endinterface

// File: rtl/loop_controller.sv
// Moore FSM sequencing a down-counter: load N, then one worker step per
// iteration with a decrement, then a single done pulse. Abort clears the run.
module loop_controller #(
  parameter int m = 6
) (
  input  logic             clk,
  input  logic             rst,
  loop_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ISSUE = 3'd3,
    DEC   = 3'd4,
    DONE  = 3'd5,
    CLR   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OPC_CLEAR = 2'd0,
    OPC_HOLD  = 2'd1,
    OPC_DEC   = 2'd2,
    OPC_LOAD  = 2'd3
  } opc_e;

  state_e       state_q, state_d;
  logic [m-1:0] n_q, n_d;

  opc_e opc_s;
  logic step_req_s;
  logic busy_s;
  logic done_s;
  logic abortable;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    abortable = 1'b1;
    case (state_q)
      IDLE: begin
        abortable = 1'b0;
        if (bus.start) begin
          n_d     = bus.n_in;
          state_d = LOAD;
        end
      end
      LOAD:  state_d = CHECK;
      CHECK: state_d = bus.z ? DONE : ISSUE;
      ISSUE: if (bus.step_ack) state_d = DEC;
      DEC:   state_d = CHECK;
      DONE:  state_d = IDLE;
      CLR: begin
        abortable = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        abortable = 1'b0;
        state_d   = IDLE;
      end
    endcase
    // Abort overrides both the worker ack and the zero flag.
    if (abortable && bus.abort) state_d = CLR;
  end

  always_comb begin
    opc_s      = OPC_HOLD;
    step_req_s = 1'b0;
    busy_s     = 1'b1;
    done_s     = 1'b0;
    case (state_q)
      IDLE:  busy_s     = 1'b0;
      LOAD:  opc_s      = OPC_LOAD;
      CHECK: opc_s      = OPC_HOLD;
      ISSUE: step_req_s = 1'b1;
      DEC:   opc_s      = OPC_DEC;
      DONE: begin
        opc_s  = OPC_CLEAR;
        done_s = 1'b1;
      end
      CLR:   opc_s      = OPC_CLEAR;
      default: busy_s   = 1'b0;
    endcase
  end

  // While reset is held the counter is told to clear and all strobes stay low,
  // independent of what the state register currently holds.
  assign bus.opc      = rst ? opc_s : OPC_CLEAR;
  assign bus.step_req = rst & step_req_s;
  assign bus.busy     = rst & busy_s;
  assign bus.done     = rst & done_s;
  assign bus.n        = n_q;
  assign bus.idx      = bus.i;

endmodule

// File: tb/tb_loop_controller.sv
// Self-checking bench for loop_controller: a behavioural down-counter plus a
// timeline model of requests and done derived from N and the worker ack delays.
module tb_loop_controller;
  localparam int M = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  loop_controller_if #(.m(M)) bus ();
  loop_controller #(.m(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Downstream counter stage driven by opc.
  logic [M-1:0] cnt_q;
  always @(posedge clk) begin
    case (bus.opc)
      2'd0: cnt_q <= '0;
      2'd2: cnt_q <= cnt_q - 1'b1;
      2'd3: cnt_q <= bus.n;
      default: cnt_q <= cnt_q;
    endcase
  end
  assign bus.i = cnt_q;
  assign bus.z = (cnt_q == '0);

  int n_assert = 0;
  int n_fail   = 0;
  int dly[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One run of N iterations. tied: ack held high. stray: start/ack pulsed while
  // busy outside ISSUE. abort_at: abort on first cycle of that request (0 = none).
  task automatic run_job(input int nn, input bit tied, input bit stray, input int abort_at);
    int cyc, nreq, ndone, age, cur_k, exp_start, exp_done, d;
    bit prev_req;
    exp_done = 3;
    for (int k = 0; k < nn; k++) exp_done += (tied ? 0 : dly[k]) + 3;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.n_in     = M'(nn);
    bus.abort    = 1'b0;
    bus.step_ack = tied;
    cyc = 0; nreq = 0; ndone = 0; age = 0; cur_k = 0; prev_req = 1'b0; exp_start = 3;
    while (1) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (!tied) bus.step_ack = 1'b0;
      if (cyc == 1) begin
        check("load_opc", bus.opc, 3);
        check("load_busy", bus.busy, 1);
      end
      if (cyc == 2) check("check_opc", bus.opc, 1);
      check("no_wrap", (bus.opc == 2'd2 && bus.z) ? 1 : 0, 0);
      if (bus.step_req && !prev_req) begin
        cur_k = nreq;
        d = tied ? 0 : dly[cur_k];
        check("req_idx", bus.idx, nn - cur_k);
        check("req_cycle", cyc, exp_start);
        exp_start += d + 3;
        nreq++;
        age = 1;
      end else if (bus.step_req) begin
        age++;
      end
      if (!bus.step_req && prev_req) check("req_len", age, (tied ? 0 : dly[cur_k]) + 1);
      prev_req = bus.step_req;
      if (bus.done) begin
        ndone++;
        check("done_cycle", cyc, exp_done);
        check("done_opc", bus.opc, 0);
      end
      if (!tied && bus.step_req && age == dly[cur_k] + 1) bus.step_ack = 1'b1;
      if (stray && !bus.step_req && bus.busy && (cyc == 2 || cyc % 4 == 0)) begin
        bus.step_ack = 1'b1;
        bus.start    = 1'b1;
        bus.n_in     = ~M'(nn);
      end
      if (abort_at != 0 && bus.step_req && age == 1 && nreq == abort_at) begin
        bus.abort    = 1'b1;
        bus.step_ack = 1'b1;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.step_ack = 1'b0;
        check("clr_opc", bus.opc, 0);
        check("clr_busy", bus.busy, 1);
        check("clr_done", bus.done, 0);
        check("clr_req", bus.step_req, 0);
        @(negedge clk);
        check("abort_idle_busy", bus.busy, 0);
        check("abort_idle_opc", bus.opc, 1);
        check("abort_req_count", nreq, abort_at);
        check("abort_done_count", ndone, 0);
        return;
      end
      if (!bus.busy) break;
      if (cyc > exp_done + 10) begin
        check("timeout", cyc, exp_done + 1);
        break;
      end
    end
    check("req_count", nreq, nn);
    check("done_count", ndone, 1);
    check("end_cycle", cyc, exp_done + 1);
    check("n_reg", bus.n, nn);
    check("idle_opc", bus.opc, 1);
    bus.step_ack = 1'b0;
    bus.start    = 1'b0;
  endtask

  initial begin
    int nr;
    bus.start = 1'b0; bus.n_in = '0; bus.abort = 1'b0; bus.step_ack = 1'b0;

    // Reset held for two cycles, then release.
    repeat (2) begin
      @(negedge clk);
      check("rst_opc", bus.opc, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_req", bus.step_req, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("idle_opc_after_rst", bus.opc, 1);
    check("idle_busy_after_rst", bus.busy, 0);
    check("n_after_rst", bus.n, 0);

    // N=3, ack one cycle after each request.
    for (int k = 0; k < 64; k++) dly[k] = 1;
    run_job(3, 1'b0, 1'b0, 0);

    // N=0: straight to done.
    run_job(0, 1'b0, 1'b0, 0);

    // N=2, slow worker, stray start/ack while busy.
    for (int k = 0; k < 64; k++) dly[k] = 5;
    run_job(2, 1'b0, 1'b1, 0);

    // N=4 aborted on the second request, then a clean N=1 run.
    for (int k = 0; k < 64; k++) dly[k] = 3;
    run_job(4, 1'b0, 1'b0, 2);
    dly[0] = 0;
    run_job(1, 1'b0, 1'b0, 0);

    // Maximum count with ack tied high.
    run_job(63, 1'b1, 1'b0, 0);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 64; k++) dly[k] = $urandom_range(0, 4);
      nr = $urandom_range(1, 9);
      run_job(nr, 1'b0, r[0], 0);
    end

    // Reset in the middle of a run.
    for (int k = 0; k < 64; k++) dly[k] = 20;
    @(negedge clk);
    bus.start = 1'b1; bus.n_in = 6'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_req", bus.step_req, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_opc", bus.opc, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_req", bus.step_req, 0);
    check("midrst_done", bus.done, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idle_opc", bus.opc, 1);
    check("midrst_idle_busy", bus.busy, 0);
    check("midrst_n", bus.n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
